// File: rtl/regfile_seq_if.sv
// Command and register-file port bundle for regfile_seq.
// slave = sequencer side, master = command source plus regfile side.
`timescale 1ns/1ps
interface regfile_seq_if #(
    parameter int W  = 16,
    parameter int AW = 2
) ();
    // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
    // the source holds its fields stable while cmd_valid is high and ready is low.
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_src;
    logic [W-1:0]  cmd_imm;
    logic [AW-1:0] rf_rsel;
    logic [W-1:0]  rf_q;
    logic [AW-1:0] rf_wsel;
    logic          rf_we;
    logic [W-1:0]  rf_d;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_q,
        output cmd_ready, rf_rsel, rf_wsel, rf_we, rf_d
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_q,
        input  cmd_ready, rf_rsel, rf_wsel, rf_we, rf_d
    );
endinterface

// File: rtl/regfile_seq.sv
// Micro-op sequencer for the 4x16 calculator register file: reads operands,
// runs the ALU op and writes back. Optional feature macro: REGFILE_SEQ_SAT_EN.
`timescale 1ns/1ps
module regfile_seq #(
    parameter int W  = 16,
    parameter int AW = 2
) (
    input  logic              ck,
    input  logic              res,
    regfile_seq_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              ovf,
    output logic [2:0]        dbg_state_o
);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WR   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] dst_q, src_q;
    logic [W-1:0]  imm_q;
    logic [W-1:0]  a_q, b_q, res_q;
    logic [AW-1:0] rsel_q, wsel_q;
    logic          zero_q, ovf_q;

    logic          accept;
    logic [W-1:0]  sum, diff, res_d;
    logic          add_ovf, sub_ovf, ovf_d;

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;

    // State register
    always_ff @(posedge ck or negedge res) begin
        if (!res) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.cmd_valid) state_d = (bus.cmd_op == OP_LOAD) ? S_EXEC : S_RD_A;
            S_RD_A: state_d = (op_q == OP_MOV) ? S_EXEC : S_RD_B;
            S_RD_B: state_d = S_EXEC;
            S_EXEC: state_d = S_WR;
            S_WR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, all from registered state
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rf_we     = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        if (state_q == S_IDLE) begin
            bus.cmd_ready = 1'b1;
            busy          = 1'b0;
        end
        if (state_q == S_WR) begin
            done      = 1'b1;
            bus.rf_we = (op_q != OP_CMP);
        end
    end

    assign bus.rf_rsel = rsel_q;
    assign bus.rf_wsel = wsel_q;
    assign bus.rf_d    = res_q;
    assign zero        = zero_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

    // B is the dst operand, A the src operand: ADD is B+A, SUB/CMP are B-A.
    assign sum     = b_q + a_q;
    assign diff    = b_q - a_q;
    assign add_ovf = (a_q[W-1] == b_q[W-1]) && (sum[W-1]  != b_q[W-1]);
    assign sub_ovf = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != b_q[W-1]);

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unique case (op_q)
            OP_LOAD: res_d = imm_q;
            OP_MOV:  res_d = a_q;
            OP_ADD: begin
                res_d = sum;
                ovf_d = add_ovf;
`ifdef REGFILE_SEQ_SAT_EN
                if (add_ovf) res_d = b_q[W-1] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = sub_ovf;
`ifdef REGFILE_SEQ_SAT_EN
                if (sub_ovf) res_d = b_q[W-1] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_AND:  res_d = b_q & a_q;
            OP_OR:   res_d = b_q | a_q;
            OP_XOR:  res_d = b_q ^ a_q;
            OP_CMP: begin
                res_d = diff;
                ovf_d = sub_ovf;
            end
            default: res_d = '0;
        endcase
    end

    // Datapath registers; read select only moves when an operand read is due
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            op_q   <= OP_LOAD;
            dst_q  <= '0;
            src_q  <= '0;
            imm_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            rsel_q <= '0;
            wsel_q <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= bus.cmd_op;
                dst_q <= bus.cmd_dst;
                src_q <= bus.cmd_src;
                imm_q <= bus.cmd_imm;
                if (bus.cmd_op != OP_LOAD) rsel_q <= bus.cmd_src;
            end
            if (state_q == S_RD_A) begin
                a_q <= bus.rf_q;
                if (op_q != OP_MOV) rsel_q <= dst_q;
            end
            if (state_q == S_RD_B) b_q <= bus.rf_q;
            if (state_q == S_EXEC) begin
                res_q  <= res_d;
                zero_q <= (res_d == '0);
                ovf_q  <= ovf_d;
                wsel_q <= dst_q;
            end
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: vector table through a behavioural regfile,
// scoreboard of expected writebacks, plus reset corner sequences.
`timescale 1ns/1ps
module tb_regfile_seq;
    localparam int W  = 16;
    localparam int AW = 2;
    localparam int EW = 24;

    localparam logic [2:0] OP_LOAD = 3'd0, OP_MOV = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_CMP = 3'd7;

`ifdef REGFILE_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [W-1:0] R2V = SAT ? 16'h7FFF : 16'h8000;

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [W-1:0]  imm;
        logic          we;
        logic [W-1:0]  d;
        logic          z;
        logic          o;
    } vec_t;

    logic ck = 1'b0;
    logic res = 1'b0;
    always #5 ck = ~ck;

    regfile_seq_if #(.W(W), .AW(AW)) bus ();
    logic       busy, done, zero, ovf;
    logic [2:0] dbg_state;

    regfile_seq #(.W(W), .AW(AW)) dut (
        .ck(ck), .res(res), .bus(bus),
        .busy(busy), .done(done), .zero(zero), .ovf(ovf),
        .dbg_state_o(dbg_state)
    );

    logic [W-1:0] mem [4] = '{default: '0};
    logic [W-1:0] shadow [4];
    assign bus.rf_q = mem[bus.rf_rsel];
    always @(posedge ck) if (bus.rf_we) mem[bus.rf_wsel] <= bus.rf_d;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    vec_t vecs [24];
    bit prev_cmd = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                                input logic [W-1:0] imm, input logic we, input logic [W-1:0] d,
                                input logic z, input logic o);
        vec_t v;
        v.op = op; v.dst = dst; v.src = src; v.imm = imm;
        v.we = we; v.d = d; v.z = z; v.o = o;
        return v;
    endfunction

    function automatic logic [2:0] lat_of(input logic [2:0] op);
        if (op == OP_LOAD) return 3'd2;
        if (op == OP_MOV)  return 3'd3;
        return 3'd4;
    endfunction

    task automatic drive_and_accept(input vec_t v);
        int n;
        @(negedge ck);
        if (prev_cmd) check("done_one_cycle", {15'd0, done}, 16'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_dst   = v.dst;
        bus.cmd_src   = v.src;
        bus.cmd_imm   = v.imm;
        n = 0;
        while (!bus.cmd_ready && n < 10) begin
            @(negedge ck);
            n++;
        end
        check("accept_ready", {15'd0, bus.cmd_ready}, 16'd1);
        @(posedge ck);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_dst   = AW'($urandom_range(0, 3));
        bus.cmd_src   = AW'($urandom_range(0, 3));
        bus.cmd_imm   = W'($urandom_range(0, 65535));
    endtask

    task automatic run_cmd(input vec_t v);
        int n;
        logic [EW-1:0] e;
        exp_q.push_back({v.we, v.dst, v.d, v.z, v.o, lat_of(v.op)});
        drive_and_accept(v);
        n = 0;
        do begin
            @(negedge ck);
            n++;
        end while (!done && n < 8);
        e = exp_q.pop_front();
        check("done_seen", {15'd0, done}, 16'd1);
        check("latency",   16'(n), {13'd0, e[2:0]});
        check("rf_we",     {15'd0, bus.rf_we}, {15'd0, e[23]});
        check("rf_wsel",   {14'd0, bus.rf_wsel}, {14'd0, e[22:21]});
        check("rf_d",      bus.rf_d, e[20:5]);
        check("zero",      {15'd0, zero}, {15'd0, e[4]});
        check("ovf",       {15'd0, ovf}, {15'd0, e[3]});
        check("busy_wr",   {15'd0, busy}, 16'd1);
        prev_cmd = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {15'd0, bus.cmd_ready}, 16'd1);
        check({tag, "_busy"},  {15'd0, busy}, 16'd0);
        check({tag, "_we"},    {15'd0, bus.rf_we}, 16'd0);
        check({tag, "_rsel"},  {14'd0, bus.rf_rsel}, 16'd0);
        check({tag, "_wsel"},  {14'd0, bus.rf_wsel}, 16'd0);
        check({tag, "_d"},     bus.rf_d, 16'd0);
        check({tag, "_flags"}, {13'd0, done, zero, ovf}, 16'd0);
        check({tag, "_state"}, {13'd0, dbg_state}, 16'd0);
    endtask

    initial begin
        vecs[0]  = mk(OP_LOAD, 2'd1, 2'd0, 16'h4C55, 1'b1, 16'h4C55, 1'b0, 1'b0);
        vecs[1]  = mk(OP_LOAD, 2'd0, 2'd0, 16'h0003, 1'b1, 16'h0003, 1'b0, 1'b0);
        vecs[2]  = mk(OP_LOAD, 2'd1, 2'd0, 16'h0005, 1'b1, 16'h0005, 1'b0, 1'b0);
        vecs[3]  = mk(OP_ADD,  2'd1, 2'd0, 16'h0000, 1'b1, 16'h0008, 1'b0, 1'b0);
        vecs[4]  = mk(OP_LOAD, 2'd2, 2'd0, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 1'b0);
        vecs[5]  = mk(OP_LOAD, 2'd3, 2'd0, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0);
        vecs[6]  = mk(OP_ADD,  2'd2, 2'd3, 16'h0000, 1'b1, R2V, 1'b0, 1'b1);
        vecs[7]  = mk(OP_CMP,  2'd1, 2'd1, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[8]  = mk(OP_SUB,  2'd1, 2'd0, 16'h0000, 1'b1, 16'h0005, 1'b0, 1'b0);
        vecs[9]  = mk(OP_SUB,  2'd0, 2'd0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        vecs[10] = mk(OP_MOV,  2'd3, 2'd2, 16'h0000, 1'b1, R2V, 1'b0, 1'b0);
        vecs[11] = mk(OP_AND,  2'd1, 2'd2, 16'h0000, 1'b1, 16'h0005 & R2V, ((16'h0005 & R2V) == 16'h0), 1'b0);
        vecs[12] = mk(OP_OR,   2'd1, 2'd3, 16'h0000, 1'b1, R2V, 1'b0, 1'b0);
        vecs[13] = mk(OP_XOR,  2'd1, 2'd1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        vecs[14] = mk(OP_SUB,  2'd0, 2'd2, 16'h0000, 1'b1, SAT ? 16'h8001 : 16'h8000, 1'b0, !SAT);
        vecs[15] = mk(OP_LOAD, 2'd0, 2'd0, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0);
        vecs[16] = mk(OP_LOAD, 2'd3, 2'd0, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0);
        vecs[17] = mk(OP_SUB,  2'd0, 2'd3, 16'h0000, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1);
        vecs[18] = mk(OP_LOAD, 2'd1, 2'd0, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0);
        vecs[19] = mk(OP_ADD,  2'd1, 2'd1, 16'h0000, 1'b1, 16'h2468, 1'b0, 1'b0);
        vecs[20] = mk(OP_LOAD, 2'd0, 2'd0, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0);
        vecs[21] = mk(OP_CMP,  2'd0, 2'd3, 16'h0000, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        vecs[22] = mk(OP_ADD,  2'd2, 2'd0, 16'h0000, 1'b1, SAT ? 16'hFFFF : 16'h0000, !SAT, !SAT);
        vecs[23] = mk(OP_LOAD, 2'd2, 2'd0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) shadow[i] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_dst   = '0;
        bus.cmd_src   = '0;
        bus.cmd_imm   = '0;

        // Power-on reset
        res = 1'b0;
        repeat (2) @(negedge ck);
        check_reset_outputs("rst");
        res = 1'b1;
        @(negedge ck);
        check("post_rst_ready", {15'd0, bus.cmd_ready}, 16'd1);

        for (int i = 0; i < 24; i++) begin
            run_cmd(vecs[i]);
            if (vecs[i].we) shadow[vecs[i].dst] = vecs[i].d;
        end

        // Abort an ADD while it sits in RD_B
        drive_and_accept(mk(OP_ADD, 2'd1, 2'd0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0));
        prev_cmd = 1'b0;
        @(negedge ck);
        check("abort_in_rd_a", {13'd0, dbg_state}, 16'd1);
        @(negedge ck);
        check("abort_in_rd_b", {13'd0, dbg_state}, 16'd2);
        res = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge ck);
        check("abort_no_we", {15'd0, bus.rf_we}, 16'd0);
        res = 1'b1;
        repeat (4) @(negedge ck);
        check("abort_idle",  {13'd0, dbg_state}, 16'd0);
        check("abort_ready", {15'd0, bus.cmd_ready}, 16'd1);
        check("abort_no_done", {15'd0, done}, 16'd0);

        for (int i = 0; i < 4; i++) check($sformatf("mem_r%0d", i), mem[i], shadow[i]);
        check("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
